cic_pdm_decimator: RTL and testbench
====================================

# cic_pdm_decimator

Fourth-order CIC decimator that converts one PDM microphone bitstream into 16-bit signed PCM samples. It is the first stage of each microphone channel. It sits directly upstream of the first half-band decimator, which takes `sample_out` as its `x_in`. Integrators run at the PDM bit rate and the comb section runs at the decimated rate. The comb section is pipelined over consecutive system clocks and signals each new sample with a one-cycle `sample_valid` strobe.

## Interface
- `DECIM`, default 32: decimation ratio R. Legal values are 16, 32 or 64 only; any other value fails elaboration.
- `LOG2D`, default 5: log2(DECIM). It is checked against DECIM at elaboration.
- Derived `W` = 2 + 4·LOG2D: internal register width (22 at default).
- Derived `SHIFT` = 4·LOG2D − 15: output right-shift (5 at default).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pdm_en` in 1: one-cycle strobe marking a valid PDM bit. Consecutive strobes are at least one clock apart.
- `pdm_in` in 1: PDM data bit. It is sampled only when `pdm_en`=1.
- `sample_out` out 16: signed PCM sample. It is held between strobes.
- `sample_valid` out 1: one-cycle strobe, high in the cycle `sample_out` updates.

## Operation
- Input mapping: `pdm_in`=1 maps to +1 and 0 maps to −1, as a W-bit two's complement value.
- Integrators I1..I4 are W-bit registers that update only when `pdm_en`=1, as a cascade: I1+=x, I2+=I1_new, I3+=I2_new, I4+=I3_new. All four update in the same cycle, so the cascade is combinational within that cycle.
- Integrator overflow wraps modulo 2^W. This is intended, not an error.
- Decimation counter `dcnt` (LOG2D bits) increments on each `pdm_en` and wraps from R−1 to 0.
- Tick: a cycle with `pdm_en`=1 and `dcnt`=R−1.
- Comb pipeline, four stages C1..C4, each W bits wide with one delay register D1..D4 (differential delay M=1):
  - Cycle after tick: C1 = I4 − D1, and D1 ← I4, where I4 already includes the tick-cycle update.
  - Each following cycle: Ck = C(k−1) − Dk, and Dk ← C(k−1).
  - All comb arithmetic is W-bit wrap-around.
- Output stage:
  - y = C4 >>> SHIFT (arithmetic shift).
  - Saturate to [−32768, +32767]. Only the +full-scale case (C4 = +2^(W−2)) actually clips.
  - Drive y onto `sample_out` and pulse `sample_valid` for one cycle.
- Settling: the first four outputs after reset carry start-up transient. Outputs from the 5th onward are valid steady-state data.
- Reset (`rst`=0 at an edge) clears:
  - all integrators, comb delays and comb pipeline registers, and the valid flags;
  - `dcnt`=0, `sample_out`=0, `sample_valid`=0.
- Reset mid-operation:
  - An in-flight comb sample is discarded and no `sample_valid` is produced for it.
  - Counting restarts, so the first tick occurs on the R-th `pdm_en` after reset deasserts.
- `pdm_en` during the comb pipeline: integrators keep running and the comb pipeline is unaffected. The spacing between ticks is at least R ≥ 16 clocks, so comb pipelines never overlap.

## Timing
- Latency: `sample_valid` is high exactly 5 clocks after the tick cycle. Counting the tick cycle as T, the comb stages occupy T+1..T+4 and the output register updates at T+5.
- Output cadence: one `sample_valid` per R `pdm_en` strobes, exactly. Example: with `pdm_en` every 4 clocks and R=32, the cadence is one strobe every 128 clocks.
- `sample_valid` is never high for two consecutive cycles.
- `sample_out` changes only in cycles where `sample_valid`=1, or on reset.
- Reset values: `sample_out`=0 and `sample_valid`=0, both in the cycle after the reset edge.

## Test plan
- **All-ones:** R=32, `pdm_en` every 4 clocks, `pdm_in`=1 constant.
  - `sample_valid` every 128 clocks.
  - From the 5th output onward, `sample_out` = 32767 (saturated +full scale).
- **All-zeros:** same cadence, `pdm_in`=0.
  - From the 5th output onward, `sample_out` = −32768.
- **Alternating 1,0,1,0,…:**
  - From the 5th output onward, `sample_out` = 0 exactly.
- **Repeating 1,1,1,0** (density 0.75, mean +0.5):
  - From the 5th output onward, `sample_out` = 16384 exactly.
- **Latency and cadence check:** `pdm_en` every clock, R=16.
  - `sample_valid` rises exactly 5 clocks after each tick.
  - Consecutive strobes are 16 clocks apart.
  - Sweep R=64 and confirm SHIFT=9 with all-ones giving 32767.
- **Mid-operation reset:** assert `rst`=0 for 1 clock, 2 clocks after a tick.
  - No `sample_valid` for the in-flight sample.
  - `sample_out`=0 after reset.
  - Next `sample_valid` comes 5 clocks after the 32nd post-reset `pdm_en`.
  - The output sequence matches a fresh start.

Source files
------------

// File: rtl/cic_pdm_decimator.sv
// ----------------------------------------------------------------------------
// cic_pdm_decimator
//
// Fourth-order CIC decimator that turns one PDM microphone bitstream into
// 16-bit signed PCM. The four integrators run at the PDM bit rate. The four
// comb stages run once per decimated sample and are spread over consecutive
// system clocks. Each new sample is flagged with a one-cycle strobe.
//
// Parameters
//   DECIM  decimation ratio R (16, 32 or 64)
//   LOG2D  log2(DECIM)
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous reset, active low
//   pdm_en        in   one-cycle strobe qualifying pdm_in
//   pdm_in        in   PDM bit (1 -> +1, 0 -> -1)
//   sample_out    out  signed PCM sample, held between strobes
//   sample_valid  out  one-cycle strobe, high in the cycle sample_out updates
// ----------------------------------------------------------------------------
module cic_pdm_decimator #(
    parameter int DECIM = 32,
    parameter int LOG2D = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pdm_en,
    input  logic        pdm_in,
    output logic [15:0] sample_out,
    output logic        sample_valid
);

    // Register width holds the full CIC gain R^4 = 2^(W-2) plus sign.
    localparam int W     = 2 + 4 * LOG2D;
    localparam int SHIFT = 4 * LOG2D - 15;

    localparam logic signed [W-1:0] POS_ONE = W'(1);
    localparam logic signed [W-1:0] NEG_ONE = W'(-1);
    localparam logic signed [W-1:0] SAT_HI  = W'(32767);
    localparam logic signed [W-1:0] SAT_LO  = W'(-32768);
    localparam logic [LOG2D-1:0]    DCNT_LAST = LOG2D'(DECIM - 1);

    generate
        if (!(DECIM == 16 || DECIM == 32 || DECIM == 64)) begin : g_bad_decim
            $error("cic_pdm_decimator: DECIM must be 16, 32 or 64");
        end
        if ((1 << LOG2D) != DECIM) begin : g_bad_log2d
            $error("cic_pdm_decimator: LOG2D must equal log2(DECIM)");
        end
    endgenerate

    // Scale the comb output to 16 bits. Only +full scale (C4 = +2^(W-2))
    // lands outside the 16-bit range after the shift.
    function automatic logic [15:0] scale_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
        s = v >>> SHIFT;
        if (s > SAT_HI) begin
            return 16'h7fff;
        end else if (s < SAT_LO) begin
            return 16'h8000;
        end else begin
            return 16'(s);
        end
    endfunction

    logic signed [W-1:0] x_in;
    logic                tick;

    logic signed [W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d, i4_q, i4_d;
    logic [LOG2D-1:0]    dcnt_q, dcnt_d;

    logic signed [W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
    logic signed [W-1:0] c_p1_q, c_p1_d, c_p2_q, c_p2_d;
    logic signed [W-1:0] c_p3_q, c_p3_d, c_p4_q, c_p4_d;
    logic                vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic                vld_p3_q, vld_p3_d, vld_p4_q, vld_p4_d;

    logic [15:0]         sample_out_q, sample_out_d;
    logic                sample_valid_q, sample_valid_d;

    always_comb begin
        i1_d           = i1_q;
        i2_d           = i2_q;
        i3_d           = i3_q;
        i4_d           = i4_q;
        dcnt_d         = dcnt_q;
        d1_d           = d1_q;
        d2_d           = d2_q;
        d3_d           = d3_q;
        d4_d           = d4_q;
        c_p1_d         = c_p1_q;
        c_p2_d         = c_p2_q;
        c_p3_d         = c_p3_q;
        c_p4_d         = c_p4_q;
        sample_out_d   = sample_out_q;

        x_in = pdm_in ? POS_ONE : NEG_ONE;
        tick = pdm_en && (dcnt_q == DCNT_LAST);

        // Integrator cascade at the PDM rate; wrap-around is intended.
        if (pdm_en) begin
            i1_d   = i1_q + x_in;
            i2_d   = i2_q + i1_d;
            i3_d   = i3_q + i2_d;
            i4_d   = i4_q + i3_d;
            dcnt_d = dcnt_q + LOG2D'(1);
        end

        // Comb stage 1: uses I4 including the tick-cycle update.
        vld_p1_d = tick;
        if (tick) begin
            c_p1_d = i4_d - d1_q;
            d1_d   = i4_d;
        end

        // Comb stage 2
        vld_p2_d = vld_p1_q;
        if (vld_p1_q) begin
            c_p2_d = c_p1_q - d2_q;
            d2_d   = c_p1_q;
        end

        // Comb stage 3
        vld_p3_d = vld_p2_q;
        if (vld_p2_q) begin
            c_p3_d = c_p2_q - d3_q;
            d3_d   = c_p2_q;
        end

        // Comb stage 4
        vld_p4_d = vld_p3_q;
        if (vld_p3_q) begin
            c_p4_d = c_p3_q - d4_q;
            d4_d   = c_p3_q;
        end

        // Output stage
        sample_valid_d = vld_p4_q;
        if (vld_p4_q) begin
            sample_out_d = scale_sat(c_p4_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            i1_q           <= '0;
            i2_q           <= '0;
            i3_q           <= '0;
            i4_q           <= '0;
            dcnt_q         <= '0;
            d1_q           <= '0;
            d2_q           <= '0;
            d3_q           <= '0;
            d4_q           <= '0;
            c_p1_q         <= '0;
            c_p2_q         <= '0;
            c_p3_q         <= '0;
            c_p4_q         <= '0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
            vld_p3_q       <= 1'b0;
            vld_p4_q       <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            i1_q           <= i1_d;
            i2_q           <= i2_d;
            i3_q           <= i3_d;
            i4_q           <= i4_d;
            dcnt_q         <= dcnt_d;
            d1_q           <= d1_d;
            d2_q           <= d2_d;
            d3_q           <= d3_d;
            d4_q           <= d4_d;
            c_p1_q         <= c_p1_d;
            c_p2_q         <= c_p2_d;
            c_p3_q         <= c_p3_d;
            c_p4_q         <= c_p4_d;
            vld_p1_q       <= vld_p1_d;
            vld_p2_q       <= vld_p2_d;
            vld_p3_q       <= vld_p3_d;
            vld_p4_q       <= vld_p4_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// ----------------------------------------------------------------------------
// tb_cic_pdm_decimator
//
// Three decimators (R = 16, 32, 64) share one clock; one is exercised at a
// time. Each tick pushes the expected sample and its arrival cycle into a
// queue; a monitor pops and compares whenever any instance strobes.
// The reference computes each output as the input sequence (zero before
// reset) convolved with the CIC impulse response (boxcar of length R
// convolved with itself four times), shifted and saturated.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cic_pdm_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [3];
    logic        en_v  [3];
    logic        in_v  [3];
    logic [15:0] out_v [3];
    logic        vld_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cic_pdm_decimator #(.DECIM(16 << g), .LOG2D(4 + g)) u_dut (
            .clk          (clk),
            .rst          (rst_v[g]),
            .pdm_en       (en_v[g]),
            .pdm_in       (in_v[g]),
            .sample_out   (out_v[g]),
            .sample_valid (vld_v[g])
        );
    end

    typedef struct {
        int ch;
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   act = 0;
    int   nstrobe = 0;
    bit   fixed_on = 0;
    int   fixed_val = 0;
    bit   mon_on = 0;
    int   rval [3] = '{16, 32, 64};
    int   shv  [3] = '{1, 5, 9};
    logic [15:0] prev [3];
    logic        rst_edge [3];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 3; g++) rst_edge[g] <= !rst_v[g];
    end

    function automatic void check(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Reference output for the sample that ends at the newest history entry.
    function automatic int model_y(int r, int sh);
        int     h[$];
        int     t[$];
        int     s;
        int     n;
        longint acc;
        longint y;
        h.push_back(1);
        repeat (4) begin
            t = {};
            for (int i = 0; i < h.size() + r - 1; i++) begin
                s = 0;
                for (int j = 0; j < r; j++)
                    if (i - j >= 0 && i - j < h.size()) s += h[i - j];
                t.push_back(s);
            end
            h = t;
        end
        n = hist.size() - 1;
        acc = 0;
        for (int j = 0; j < h.size() && n - j >= 0; j++)
            acc += longint'(h[j]) * longint'(hist[n - j]);
        y = acc >>> sh;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    // Monitor: pops the scoreboard on every strobe; flags unexpected
    // strobes and output changes that are not accompanied by a strobe.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int g = 0; g < 3; g++) begin
                if (vld_v[g] === 1'b1) begin
                    if (exp_q.size() == 0 || exp_q[0].ch != g) begin
                        check($sformatf("unexpected_valid_ch%0d", g), 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("latency_ch%0d", g), cyc, e.cyc);
                        check($sformatf("sample_ch%0d", g), int'($signed(out_v[g])), e.val);
                    end
                end else if (out_v[g] !== prev[g] && !rst_edge[g]) begin
                    check($sformatf("hold_ch%0d", g), int'($signed(out_v[g])), int'($signed(prev[g])));
                end
                prev[g] = out_v[g];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One PDM strobe on the active instance; queues the expected sample
    // when this strobe completes a decimation period.
    task automatic strobe(input int b);
        exp_t e;
        en_v[act] = 1'b1;
        in_v[act] = b[0];
        hist.push_back(b != 0 ? 1 : -1);
        nstrobe++;
        if (nstrobe % rval[act] == 0) begin
            e.ch  = act;
            e.cyc = cyc + 5;
            if (fixed_on && nstrobe / rval[act] >= 5) e.val = fixed_val;
            else e.val = model_y(rval[act], shv[act]);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        en_v[act] = 1'b0;
    endtask

    task automatic do_reset();
        exp_q.delete();
        hist.delete();
        nstrobe = 0;
        rst_v[act] = 1'b0;
        @(posedge clk);
        #1;
        rst_v[act] = 1'b1;
        check("reset_sample_out", int'(out_v[act]), 0);
        check("reset_sample_valid", int'(vld_v[act]), 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            idle(1);
            k++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // pattern: 0 ones, 1 zeros, 2 alternating, 3 1110, 4 random
    function automatic int pat_bit(int pat, int i);
        case (pat)
            0: return 1;
            1: return 0;
            2: return (i % 2 == 0) ? 1 : 0;
            3: return (i % 4 != 3) ? 1 : 0;
            default: return int'($urandom_range(0, 1));
        endcase
    endfunction

    // gap < 0 selects a random 0..3 idle clocks between strobes.
    task automatic run(input int ch, input int pat, input int nout, input int gap,
                       input bit fon, input int fval);
        drain();
        act = ch;
        fixed_on = fon;
        fixed_val = fval;
        do_reset();
        for (int i = 0; i < nout * rval[ch]; i++) begin
            strobe(pat_bit(pat, i));
            if (gap < 0) idle(int'($urandom_range(0, 3)));
            else idle(gap);
        end
        drain();
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_v[g] = 1'b0;
            en_v[g]  = 1'b0;
            in_v[g]  = 1'b0;
            prev[g]  = 16'h0;
        end
        idle(2);
        for (int g = 0; g < 3; g++) rst_v[g] = 1'b1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("init_sample_out_ch%0d", g), int'(out_v[g]), 0);
            check($sformatf("init_sample_valid_ch%0d", g), int'(vld_v[g]), 0);
        end
        mon_on = 1'b1;

        // R=32, pdm_en every 4 clocks, fixed steady-state values.
        run(1, 0, 10, 3, 1'b1, 32767);
        run(1, 1, 8, 3, 1'b1, -32768);
        run(1, 2, 8, 3, 1'b1, 0);
        run(1, 3, 8, 3, 1'b1, 16384);
        run(1, 4, 6, -1, 1'b0, 0);

        // R=16 with pdm_en every clock.
        run(0, 0, 8, 0, 1'b1, 32767);
        run(0, 4, 8, 0, 1'b0, 0);
        run(0, 3, 7, -1, 1'b1, 16384);

        // R=64.
        run(2, 0, 7, 0, 1'b1, 32767);
        run(2, 4, 4, 1, 1'b0, 0);

        // Mid-operation reset two clocks after a tick on R=32.
        drain();
        act = 1;
        fixed_on = 1'b0;
        do_reset();
        for (int i = 0; i < 3 * 32; i++) begin
            strobe(pat_bit(4, i));
            idle(3);
        end
        drain();
        for (int i = 0; i < 32; i++) begin
            strobe(pat_bit(4, i));
            if (i != 31) idle(3);
        end
        idle(1);
        do_reset();
        for (int i = 0; i < 5 * 32; i++) begin
            strobe(pat_bit(4, i));
            idle(3);
        end
        drain();
        idle(40);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
